// File: rtl/diff_pkt_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : diff_pkt_buffer_pkg
// Brief   : Shared widths/defaults for the diff collection -> host DMA path.
// Revision: 1.0  initial release
// ============================================================================
package diff_pkt_buffer_pkg;
    localparam int DIFF_WORD_W    = 512;
    localparam int DIFF_PKT_WORDS = 16;
    localparam int DIFF_BUF_DEPTH = 64;
    localparam int DIFF_CNT_W     = 16;
endpackage
`default_nettype wire

// File: rtl/diff_pkt_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : diff_pkt_buffer_if
// Brief   : Upstream word feed (no ready) plus downstream packet stream to host.
// Revision: 1.0  initial release
// ============================================================================
interface diff_pkt_buffer_if #(
    parameter int DATA_W = diff_pkt_buffer_pkg::DIFF_WORD_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport slave  (input  in_data, in_valid, in_last, m_ready,
                    output m_data, m_valid, m_last);
    modport master (output in_data, in_valid, in_last, m_ready,
                    input  m_data, m_valid, m_last);
endinterface
`default_nettype wire

// File: rtl/diff_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : diff_buf_ram
// Brief   : Simple dual-port RAM, registered write, asynchronous read.
// Revision: 1.0  initial release
// ============================================================================
module diff_buf_ram #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic [AW-1:0]    i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/diff_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module  : diff_pkt_buffer
// Brief   : FWFT buffer for diff words; packetizes to host, counts overflow drops.
// Revision: 1.0  initial release
// ============================================================================
module diff_pkt_buffer
    import diff_pkt_buffer_pkg::*;
#(
    parameter int DATA_W    = DIFF_WORD_W,
    parameter int DEPTH     = DIFF_BUF_DEPTH,
    parameter int PKT_WORDS = DIFF_PKT_WORDS,
    parameter int CNT_W     = DIFF_CNT_W
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    diff_pkt_buffer_if.slave            bus,
    input  wire logic                   clr_stats,
    output logic [$clog2(DEPTH):0]      fill,
    output logic                        ovf_sticky,
    output logic [CNT_W-1:0]            ovf_cnt,
    output logic [CNT_W-1:0]            pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(PKT_WORDS + 1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic [BW-1:0]    r_beat_ctr;
    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_drop;
    logic             w_pop;
    logic             w_m_last;
    logic [DATA_W:0]  w_head;

    // Full is judged on the registered count only, so a same-cycle pop never frees room for a write.
    assign w_full   = (r_fill == (AW+1)'(DEPTH));
    assign w_empty  = (r_fill == '0);
    assign w_wr     = bus.in_valid && !w_full;
    assign w_drop   = bus.in_valid && w_full;
    assign w_pop    = !w_empty && bus.m_ready;
    assign w_m_last = !w_empty && (w_head[DATA_W] || (r_beat_ctr == BW'(PKT_WORDS - 1)));

    diff_buf_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.in_last, bus.in_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_beat_ctr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_beat_ctr <= w_m_last ? '0 : r_beat_ctr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_cnt    <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_drop) begin
                r_ovf_sticky <= 1'b1;
                if (r_ovf_cnt != '1) begin
                    r_ovf_cnt <= r_ovf_cnt + 1'b1;
                end
            end
            if (w_pop && w_m_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign bus.m_data  = w_head[DATA_W-1:0];
    assign bus.m_valid = !w_empty;
    assign bus.m_last  = w_m_last;
    assign fill        = r_fill;
    assign ovf_sticky  = r_ovf_sticky;
    assign ovf_cnt     = r_ovf_cnt;
    assign pkt_cnt     = r_pkt_cnt;
endmodule
`default_nettype wire
